regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width of each register.
REQ-002 SHALL have parameter AW, default 5: address width; depth DEPTH = 2**AW registers.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port we  input  1  write enable.
REQ-006 SHALL have port waddr  input  AW  write address.
REQ-007 SHALL have port wdata  input  XLEN  write data.
REQ-008 SHALL have port rs1_addr  input  AW  read port 1 address.
REQ-009 SHALL have port rs2_addr  input  AW  read port 2 address.
REQ-010 SHALL have port rs1_data  output  XLEN  read port 1 data, combinational.
REQ-011 SHALL have port rs2_data  output  XLEN  read port 2 data, combinational.
REQ-012 SHALL have port rs1_busy  output  1  scoreboard pending bit of rs1_addr.
REQ-013 SHALL have port rs2_busy  output  1  scoreboard pending bit of rs2_addr.
REQ-014 SHALL have port claim  input  1  mark claim_addr as pending a future write.
REQ-015 SHALL have port claim_addr  input  AW  register being claimed.
REQ-016 SHALL have port clr_req  input  1  one-cycle pulse starting a sequential clear.
REQ-017 SHALL have port clr_busy  output  1  high while the clear sequence runs.

Function
REQ-018 SHALL write wdata to register waddr on the rising edge when we=1, waddr!=0 and state is IDLE.
REQ-019 SHALL read register 0 as all-zero and report its busy bit as 0; writes and claims to address 0 SHALL be ignored.
REQ-020 SHALL hold one busy bit per register: claim=1 sets busy[claim_addr] at the next edge; a qualifying write clears busy[waddr] at the same edge it updates data.
REQ-021 SHALL give claim priority when claim and write target the same address in one cycle: data written, busy ends set.
REQ-022 SHALL implement a two-state FSM IDLE/CLEAR; IDLE->CLEAR on clr_req=1 at an edge, with internal counter loaded to 1.
REQ-023 SHALL in CLEAR zero register[counter] and busy[counter] each cycle, increment counter, and return to IDLE at the edge that clears register DEPTH-1 (DEPTH-1 cycles total).
REQ-024 SHALL drive clr_busy=1 exactly while state is CLEAR.
REQ-025 SHALL ignore we, claim and clr_req while in CLEAR; reads remain functional and return current contents.
REQ-026 SHALL without bypass return pre-edge register contents on reads of an address being written that cycle.

Reset
REQ-027 SHALL on rst=0, asynchronously and independent of clk, zero all registers and busy bits, set state IDLE and counter 0.
REQ-028 SHALL abort an in-progress clear on rst=0; after release the block is in IDLE with all registers zero.
REQ-029 SHALL hold clr_busy=0, rs*_busy=0 and rs*_data=0 while rst=0.

Configuration
REQ-030 SHALL when macro REGFILE_SB_BYPASS_EN is defined forward wdata to rsN_data and force rsN_busy=0 combinationally when we=1, waddr=rsN_addr, waddr!=0, state IDLE, and no same-cycle claim of that address.
REQ-031 SHALL when REGFILE_SB_BYPASS_EN is undefined contain no forwarding path; behaviour per REQ-026.

Verification
REQ-032 Reset then write x5=0xDEADBEEF, next cycle read rs1_addr=5 -> rs1_data=0xDEADBEEF, rs1_busy=0.
REQ-033 Write x0=0x12345678, claim x0 -> rs2_addr=0 gives rs2_data=0, rs2_busy=0.
REQ-034 claim x7 -> rs1_busy=1 next cycle; write x7=0xA5 -> busy=0 and data 0xA5 after edge; same-cycle claim+write x7=0x3C -> data 0x3C, busy=1.
REQ-035 Fill x1..x31 with index values, pulse clr_req -> clr_busy high exactly 31 cycles, x1..x31 read 0 afterwards; we=1 to x9 during CLEAR has no effect.
REQ-036 Assert rst=0 mid-clear (counter=10) between clock edges -> immediate zero outputs, clr_busy=0; after release IDLE, all registers 0.
REQ-037 With REGFILE_SB_BYPASS_EN: we=1 waddr=3 wdata=0x55, rs1_addr=3 same cycle -> rs1_data=0x55; without macro -> previous x3 value.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with a per-register scoreboard and a sequential clear engine.
//   XLEN : data width of each register
//   AW   : address width, DEPTH = 2**AW registers; register 0 reads as zero
// Ports:
//   clk, rst (async, active-low)
//   we/waddr/wdata            : write port
//   rs1_addr/rs2_addr         : read addresses
//   rs1_data/rs2_data         : combinational read data
//   rs1_busy/rs2_busy         : combinational scoreboard pending bits
//   claim/claim_addr          : mark a register as pending a future write
//   clr_req                   : start a sequential clear of registers 1..DEPTH-1
//   clr_busy                  : high while the clear sequence runs
// Optional feature: define REGFILE_SB_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_sb #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            claim,
  input  logic [AW-1:0]   claim_addr,
  input  logic            clr_req,
  output logic            clr_busy
);

  localparam int unsigned DEPTH = 2**AW;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [AW-1:0]   cnt;
  logic            wr_en;
  logic            clm_en;

  // Writes and claims only take effect in IDLE and never touch register 0.
  assign wr_en  = (state == IDLE) && we && (waddr != '0);
  assign clm_en = (state == IDLE) && claim && (claim_addr != '0);

  assign clr_busy = (state == CLEAR);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = CLEAR;
      CLEAR:   if (cnt == AW'(DEPTH - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Register array, scoreboard and clear counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en) begin
            regs[waddr] <= wdata;
            busy[waddr] <= 1'b0;
          end
          // Claim is applied last so it wins over a same-address write.
          if (clm_en) begin
            busy[claim_addr] <= 1'b1;
          end
          if (clr_req) begin
            cnt <= AW'(1);
          end
        end
        CLEAR: begin
          regs[cnt] <= '0;
          busy[cnt] <= 1'b0;
          cnt       <= cnt + AW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef REGFILE_SB_BYPASS_EN
  logic fwd_ok;
  // Forward only a write that will land and is not being re-claimed this cycle.
  assign fwd_ok = wr_en && !(clm_en && (claim_addr == waddr));
`endif

  // Read ports; held at zero while reset is asserted
  always_comb begin
    rs1_data = '0;
    rs1_busy = 1'b0;
    rs2_data = '0;
    rs2_busy = 1'b0;
    if (rst) begin
      if (rs1_addr != '0) begin
        rs1_data = regs[rs1_addr];
        rs1_busy = busy[rs1_addr];
      end
      if (rs2_addr != '0) begin
        rs2_data = regs[rs2_addr];
        rs2_busy = busy[rs2_addr];
      end
`ifdef REGFILE_SB_BYPASS_EN
      if (fwd_ok && (waddr == rs1_addr)) begin
        rs1_data = wdata;
        rs1_busy = 1'b0;
      end
      if (fwd_ok && (waddr == rs2_addr)) begin
        rs2_data = wdata;
        rs2_busy = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus random traffic
// compared against an array-based reference model of the register file.
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        claim;
  logic [4:0]  claim_addr;
  logic        clr_req;
  logic        clr_busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mdl [32];
  logic        bm  [32];
  logic        m_clearing;
  int          m_left;

  regfile_sb #(.XLEN(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .claim(claim), .claim_addr(claim_addr),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      mdl[i] = 32'h0;
      bm[i]  = 1'b0;
    end
    m_clearing = 1'b0;
    m_left     = 0;
  endfunction

  // One clock edge of the model: a clear wipes registers 1..31 in ascending order, one per edge.
  function automatic void model_edge();
    int idx;
    if (!rst) return;
    if (m_clearing) begin
      idx = 32 - m_left;
      mdl[idx] = 32'h0;
      bm[idx]  = 1'b0;
      m_left   = m_left - 1;
      if (m_left == 0) m_clearing = 1'b0;
    end else begin
      if (we && waddr != 5'd0) begin
        mdl[waddr] = wdata;
        bm[waddr]  = 1'b0;
      end
      if (claim && claim_addr != 5'd0) bm[claim_addr] = 1'b1;
      if (clr_req) begin
        m_clearing = 1'b1;
        m_left     = 31;
      end
    end
  endfunction

  function automatic logic fwd_hit(input logic [4:0] a);
`ifdef REGFILE_SB_BYPASS_EN
    return rst && we && !m_clearing && waddr != 5'd0 && waddr == a &&
           !(claim && claim_addr == waddr);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (!rst || a == 5'd0) return 32'h0;
    if (fwd_hit(a)) return wdata;
    return mdl[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (!rst || a == 5'd0) return 1'b0;
    if (fwd_hit(a)) return 1'b0;
    return bm[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model, away from the clock edge.
  task automatic chk(input string tag);
    #1;
    chk_val({tag, ".rs1_data"}, rs1_data, exp_data(rs1_addr));
    chk_val({tag, ".rs1_busy"}, 32'(rs1_busy), 32'(exp_busy(rs1_addr)));
    chk_val({tag, ".rs2_data"}, rs2_data, exp_data(rs2_addr));
    chk_val({tag, ".rs2_busy"}, 32'(rs2_busy), 32'(exp_busy(rs2_addr)));
    chk_val({tag, ".clr_busy"}, 32'(clr_busy), 32'(rst && m_clearing));
  endtask

  task automatic idle_inputs();
    we = 1'b0; waddr = 5'd0; wdata = 32'h0;
    claim = 1'b0; claim_addr = 5'd0; clr_req = 1'b0;
  endtask

  task automatic fill_index();
    for (int i = 1; i < 32; i++) begin
      idle_inputs();
      we = 1'b1; waddr = 5'(i); wdata = 32'(i);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    int ncyc;
    int n;
    rst = 1'b0;
    idle_inputs();
    rs1_addr = 5'd5; rs2_addr = 5'd7;
    model_reset();
    chk("reset");
    tick();
    rst = 1'b1;
    chk("post_reset");

    // Write x5 then read it back
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; rs1_addr = 5'd5;
    chk("wr_x5_same");
    tick();
    idle_inputs();
    chk("rd_x5");
    chk_val("rd_x5_const", rs1_data, 32'hDEADBEEF);
    chk_val("rd_x5_busy_const", 32'(rs1_busy), 32'h0);

    // Writes and claims to x0 are ignored
    we = 1'b1; waddr = 5'd0; wdata = 32'h12345678; claim = 1'b1; claim_addr = 5'd0;
    rs2_addr = 5'd0;
    tick();
    idle_inputs();
    chk("x0");
    chk_val("x0_const", rs2_data, 32'h0);

    // Scoreboard: claim, write clears, same-cycle claim+write keeps busy
    rs1_addr = 5'd7;
    claim = 1'b1; claim_addr = 5'd7;
    tick();
    idle_inputs();
    chk("claim_x7");
    chk_val("claim_x7_const", 32'(rs1_busy), 32'h1);
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5;
    tick();
    idle_inputs();
    chk("wr_x7");
    chk_val("wr_x7_const", {rs1_data[30:0], rs1_busy}, {31'hA5, 1'b0});
    we = 1'b1; waddr = 5'd7; wdata = 32'h3C; claim = 1'b1; claim_addr = 5'd7;
    chk("claimwr_x7_same");
    tick();
    idle_inputs();
    chk("claimwr_x7");
    chk_val("claimwr_x7_const", {rs1_data[30:0], rs1_busy}, {31'h3C, 1'b1});

    // Read of an address being written this cycle
    we = 1'b1; waddr = 5'd3; wdata = 32'h11;
    tick();
    we = 1'b1; waddr = 5'd3; wdata = 32'h55; rs1_addr = 5'd3;
    chk("bypass_x3");
`ifdef REGFILE_SB_BYPASS_EN
    chk_val("bypass_x3_const", rs1_data, 32'h55);
`else
    chk_val("bypass_x3_const", rs1_data, 32'h11);
`endif
    tick();
    idle_inputs();

    // Random traffic including occasional clears
    for (int c = 0; c < 400; c++) begin
      we         = 1'($urandom_range(0, 1));
      waddr      = 5'($urandom_range(0, 31));
      wdata      = $urandom;
      claim      = ($urandom_range(0, 3) == 0);
      claim_addr = ($urandom_range(0, 1) == 0) ? waddr : 5'($urandom_range(0, 31));
      clr_req    = ($urandom_range(0, 59) == 0);
      rs1_addr   = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
      rs2_addr   = 5'($urandom_range(0, 31));
      chk("rand");
      tick();
    end
    idle_inputs();

    // Drain any clear left running by the random phase
    n = 0;
    while (m_clearing && n < 64) begin
      tick();
      n++;
    end
    chk_val("drain_timeout", 32'(m_clearing), 32'h0);

    // Full clear: busy for exactly 31 cycles, writes ignored meanwhile
    fill_index();
    clr_req = 1'b1; rs1_addr = 5'd9; rs2_addr = 5'd31;
    chk("clr_start");
    tick();
    idle_inputs();
    ncyc = 0;
    for (int c = 0; c < 60; c++) begin
      we = 1'b1; waddr = 5'd9; wdata = 32'hFFFF_FFFF; claim = 1'b1; claim_addr = 5'd9;
      chk("clr_run");
      if (!clr_busy) break;
      ncyc++;
      tick();
    end
    idle_inputs();
    chk_val("clr_cycles", 32'(ncyc), 32'd31);
    for (int i = 1; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(32 - i);
      #1;
      chk_val("clr_zero", rs1_data, 32'h0);
      chk_val("clr_busy_zero", 32'(rs1_busy), 32'h0);
      tick();
    end

    // Reset in the middle of a clear (counter at 10)
    fill_index();
    clr_req = 1'b1;
    tick();
    idle_inputs();
    for (int c = 0; c < 9; c++) tick();
    rs1_addr = 5'd20; rs2_addr = 5'd10;
    chk("pre_abort");
    chk_val("pre_abort_x20", rs1_data, 32'd20);
    #1;
    rst = 1'b0;
    model_reset();
    chk("abort");
    chk_val("abort_rs1", rs1_data, 32'h0);
    chk_val("abort_clr_busy", 32'(clr_busy), 32'h0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      chk("post_abort");
      chk_val("post_abort_zero", rs1_data, 32'h0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
